// File: rtl/pheap_pkg.sv
// rtl/pheap_pkg.sv - shared op/state types and capacity helper for the pipelined heap front end
package pheap_pkg;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_POP    = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } sched_state_e;

  // A full binary heap with levels 0..levels holds 2**(levels+1)-1 elements.
  function automatic int cap(input int levels);
    return (1 << (levels + 1)) - 1;
  endfunction

endpackage

// File: rtl/pheap_op_sched_if.sv
// rtl/pheap_op_sched_if.sv - request, flush and status bundle between a requester and the op scheduler
interface pheap_op_sched_if #(
  parameter int LEVELS = 4
) ();
  import pheap_pkg::*;

  logic                      req_valid;
  op_e                       req_op;
  logic                      req_ready;
  logic                      flush_req;
  logic                      flush_done;
  logic                      issue_valid;
  op_e                       issue_op;
  logic [LEVELS:0]           lvl_busy;
  logic [$clog2(LEVELS):0]   top_lvl;
  logic                      pipe_idle;
  logic [LEVELS:0]           count;
  logic                      full;
  logic                      empty;

  modport master (
    output req_valid, req_op, flush_req,
    input  req_ready, flush_done, issue_valid, issue_op,
           lvl_busy, top_lvl, pipe_idle, count, full, empty
  );

  modport slave (
    input  req_valid, req_op, flush_req,
    output req_ready, flush_done, issue_valid, issue_op,
           lvl_busy, top_lvl, pipe_idle, count, full, empty
  );

endinterface

// File: rtl/pri_enc.sv
// rtl/pri_enc.sv - highest-set-bit encoder over the level busy vector, plus an all-clear flag
module pri_enc #(
  parameter int LEVELS = 4
) (
  input  logic [LEVELS:0]         a,
  output logic [$clog2(LEVELS):0] y,
  output logic                    idle
);
  localparam int YW = $clog2(LEVELS) + 1;

  // Later iterations overwrite earlier ones, so the deepest set bit wins.
  always_comb begin
    y = '0;
    for (int k = 0; k <= LEVELS; k++) begin
      if (a[k]) y = YW'(k);
    end
  end

  assign idle = ~|a;

endmodule

// File: rtl/pheap_op_sched.sv
// rtl/pheap_op_sched.sv - level-0 issue scheduler: op spacing, occupancy tracking, element count, drain/flush
module pheap_op_sched
  import pheap_pkg::*;
#(
  parameter int LEVELS    = 4,
  parameter int ISSUE_GAP = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  pheap_op_sched_if.slave        bus
);
  localparam int              CAP   = cap(LEVELS);
  localparam logic [LEVELS:0] CAP_V = CAP[LEVELS:0];
  localparam logic [LEVELS:0] ONE   = {{LEVELS{1'b0}}, 1'b1};

  sched_state_e    state, state_nxt;
  logic [LEVELS:0] lvl_busy;
  logic [LEVELS:0] count;
  logic            gap_ok;
  logic            op_ok;
  logic            ready;
  logic            issue;
  logic            done;
  logic            idle;

  // Recent issues still sitting in the shallow levels block a new issue.
  if (ISSUE_GAP <= 1) begin : g_gap_none
    assign gap_ok = 1'b1;
  end else begin : g_gap_window
    assign gap_ok = ~|lvl_busy[ISSUE_GAP-2:0];
  end

  assign op_ok = (bus.req_op == OP_INSERT) ? ~bus.full : ~bus.empty;
  assign issue = bus.req_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.flush_req) state_nxt = DRAIN;
      DRAIN:   if (idle)          state_nxt = CLEAR;
      CLEAR:                      state_nxt = RUN;
      default:                    state_nxt = RUN;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      RUN:     ready = ~bus.flush_req & gap_ok & op_ok;
      CLEAR:   done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_busy <= '0;
    else        lvl_busy <= {lvl_busy[LEVELS-1:0], issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state == CLEAR) begin
      count <= '0;
    end else if (issue) begin
      count <= (bus.req_op == OP_INSERT) ? count + ONE : count - ONE;
    end
  end

  pri_enc #(.LEVELS(LEVELS)) u_pri_enc (
    .a    (lvl_busy),
    .y    (bus.top_lvl),
    .idle (idle)
  );

  assign bus.req_ready   = ready;
  assign bus.issue_valid = issue;
  assign bus.issue_op    = bus.req_op;
  assign bus.flush_done  = done;
  assign bus.lvl_busy    = lvl_busy;
  assign bus.pipe_idle   = idle;
  assign bus.count       = count;
  assign bus.full        = (count == CAP_V);
  assign bus.empty       = (count == '0);

endmodule

// File: tb/tb_pheap_op_sched.sv
// tb/tb_pheap_op_sched.sv - randomized scoreboard bench for pheap_op_sched against a cycle-history reference model
module tb_pheap_op_sched;
  import pheap_pkg::*;

  localparam int L   = 4;
  localparam int GAP = 2;
  localparam int CAP = 31;
  localparam int M_RUN = 0, M_DRAIN = 1, M_CLEAR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pheap_op_sched_if #(.LEVELS(L)) bus ();

  pheap_op_sched #(.LEVELS(L), .ISSUE_GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int cnt;
  } sb_t;

  sb_t sb[$];
  int  iss_t[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_iss = -1000;
  int  m_count = 0;
  int  mode = M_RUN;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    iss_t.delete();
    sb.delete();
    last_iss = -1000;
    m_count  = 0;
    mode     = M_RUN;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_lvl_busy"},    int'(bus.lvl_busy), 0);
    chk({tag, "_count"},       int'(bus.count), 0);
    chk({tag, "_empty"},       int'(bus.empty), 1);
    chk({tag, "_full"},        int'(bus.full), 0);
    chk({tag, "_pipe_idle"},   int'(bus.pipe_idle), 1);
    chk({tag, "_top_lvl"},     int'(bus.top_lvl), 0);
    chk({tag, "_flush_done"},  int'(bus.flush_done), 0);
    chk({tag, "_issue_valid"}, int'(bus.issue_valid), 0);
    chk({tag, "_ready_ins"},   int'(bus.req_ready), 1);
  endtask

  // One clock cycle: drive at the falling edge, predict from issue history, check, advance.
  task automatic step(input bit v, input bit op, input bit fl);
    logic [L:0] be;
    int         tl;
    bit         gap, rdy, iss;
    bus.req_valid = v;
    bus.req_op    = op_e'(op);
    bus.flush_req = fl;
    #1;
    while (iss_t.size() > 0 && cyc - iss_t[0] > L + 1) void'(iss_t.pop_front());
    be = '0;
    tl = 0;
    foreach (iss_t[i]) begin
      int k;
      k = cyc - iss_t[i] - 1;
      if (k >= 0 && k <= L) be[k] = 1'b1;
    end
    for (int k = 0; k <= L; k++) if (be[k]) tl = k;
    gap = (cyc - last_iss) >= GAP;
    rdy = (mode == M_RUN) && !fl && gap && (op == 1'b0 ? m_count < CAP : m_count > 0);
    chk("req_ready",  int'(bus.req_ready), int'(rdy));
    chk("lvl_busy",   int'(bus.lvl_busy), int'(be));
    chk("top_lvl",    int'(bus.top_lvl), tl);
    chk("pipe_idle",  int'(bus.pipe_idle), int'(be == '0));
    chk("count",      int'(bus.count), m_count);
    chk("full",       int'(bus.full), int'(m_count == CAP));
    chk("empty",      int'(bus.empty), int'(m_count == 0));
    chk("flush_done", int'(bus.flush_done), int'(mode == M_CLEAR));
    iss = v && rdy;
    if (iss) begin
      sb.push_back('{op: int'(op), cnt: m_count});
      iss_t.push_back(cyc);
      last_iss = cyc;
      m_count  = op ? m_count - 1 : m_count + 1;
    end
    case (mode)
      M_RUN:   if (fl) mode = M_DRAIN;
      M_DRAIN: if (be == '0) mode = M_CLEAR;
      default: begin mode = M_RUN; m_count = 0; end
    endcase
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: every issue the DUT presents must match the oldest predicted issue.
  always @(negedge clk) begin
    sb_t e;
    #2;
    if (bus.issue_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL issue_unexpected: got issue_valid=1, expected no issue (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("issue_op",    int'(bus.issue_op), e.op);
        chk("issue_count", int'(bus.count), e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_INSERT;
    bus.flush_req = 1'b0;
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back inserts: issues every other cycle, pipeline fills to 10101.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

    // Pop-when-empty stall after a clear, then insert/pop round trip.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8 && mode != M_RUN; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Fill to capacity, stall on full, then one pop.
    for (int i = 0; i < 200 && m_count < CAP; i++) step(1'b1, 1'b0, 1'b0);
    chk("fill_reached", m_count, CAP);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Flush raised mid-traffic with a valid request pending.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8 && mode != M_RUN; i++) step(1'b0, 1'b0, 1'b0);
    chk("flush_returned_run", mode, M_RUN);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

    // Async reset while draining with two ops in flight.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    bus.req_valid = 1'b0;
    bus.flush_req = 1'b0;
    #1;
    chk("drain_lvl_busy", int'(bus.lvl_busy), 5'b01010);
    chk("drain_flush_done", int'(bus.flush_done), 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("midrst");
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Random traffic: insert-heavy, pop-heavy, and mixed phases with sparse flushes.
    for (int i = 0; i < 600; i++) begin
      int  ph;
      bit  v, op, fl;
      ph = i / 200;
      v  = $urandom_range(0, 3) != 0;
      case (ph)
        0:       op = $urandom_range(0, 9) < 2;
        1:       op = $urandom_range(0, 9) < 8;
        default: op = $urandom_range(0, 1) == 1;
      endcase
      fl = $urandom_range(0, 59) == 0;
      step(v, op, fl);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
